// File: rtl/memory_map_pkg.sv
// ============================================================================
// memory_map_pkg: MMIO offsets, STATUS bit positions and the address decoder.
// Rev 1.0
// ============================================================================
`default_nettype none

package memory_map_pkg;

  localparam logic [1:0] OFF_TXDATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS   = 2'd1;
  localparam logic [1:0] OFF_CYCLE_LO = 2'd2;
  localparam logic [1:0] OFF_CYCLE_HI = 2'd3;

  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 8;

  typedef enum logic [2:0] {
    TGT_RAM      = 3'd0,
    TGT_TXDATA   = 3'd1,
    TGT_STATUS   = 3'd2,
    TGT_CYCLE_LO = 3'd3,
    TGT_CYCLE_HI = 3'd4
  } target_e;

  // Only bit 31 selects the region; inside MMIO only the word offset bits matter.
  function automatic target_e decode_target(input logic [31:0] addr, input logic mmio_bit);
    target_e tgt;
    tgt = TGT_RAM;
    if (addr[31] == mmio_bit) begin
      case (addr[3:2])
        OFF_TXDATA:   tgt = TGT_TXDATA;
        OFF_STATUS:   tgt = TGT_STATUS;
        OFF_CYCLE_LO: tgt = TGT_CYCLE_LO;
        default:      tgt = TGT_CYCLE_HI;
      endcase
    end
    return tgt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_fifo.sv
// ============================================================================
// tx_fifo: power-of-2 circular FIFO with a registered head output.
// Rev 1.0
// ============================================================================
`default_nettype none

module tx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] storage_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
    // The byte being written this edge is not in storage yet; forward it if it becomes the head.
    head_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : storage_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) storage_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_data = head_q;
  assign count     = count_q;
  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/memory_responder.sv
// ============================================================================
// memory_responder: word RAM plus MMIO console FIFO and cycle counter.
// Optional feature macro: MEMORY_RESPONDER_CYCLE_COUNTER_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module memory_responder #(
  parameter int          MEMORY_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE     = 32'h8000_0000,
  parameter int          TX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] read_memory_address,
  output logic [31:0] read_memory_data,
  input  logic [31:0] write_memory_address,
  input  logic [31:0] write_memory_data,
  input  logic [31:0] write_memory_mask,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  import memory_map_pkg::*;

  localparam int IDX_W = $clog2(MEMORY_WORDS);
  localparam int CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

  logic [31:0]      mem [MEMORY_WORDS];
  logic [IDX_W-1:0] rd_idx, wr_idx;
  target_e          rd_tgt, wr_tgt;
  logic             wr_en, txdata_wr, ovf_clear;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_head;
  logic [31:0]      status_word, cycle_lo, cycle_hi;
  logic [31:0]      read_data_d, read_data_q;
  logic             overflow_d, overflow_q;
  logic             unused_addr_bits;

  assign rd_idx = read_memory_address[IDX_W+1:2];
  assign wr_idx = write_memory_address[IDX_W+1:2];
  assign rd_tgt = decode_target(read_memory_address, MMIO_BASE[31]);
  assign wr_tgt = decode_target(write_memory_address, MMIO_BASE[31]);
  assign wr_en  = |write_memory_mask;

  assign unused_addr_bits = ^{read_memory_address[30:IDX_W+2], read_memory_address[1:0],
                              write_memory_address[30:IDX_W+2], write_memory_address[1:0]};

  always_ff @(posedge clk) begin
    if (wr_en && (wr_tgt == TGT_RAM))
      mem[wr_idx] <= (mem[wr_idx] & ~write_memory_mask) | (write_memory_data & write_memory_mask);
  end

  assign txdata_wr = wr_en && (wr_tgt == TGT_TXDATA) && (|write_memory_mask[7:0]);
  assign ovf_clear = wr_en && (wr_tgt == TGT_STATUS)
                     && write_memory_data[STATUS_OVERFLOW_BIT] && write_memory_mask[STATUS_OVERFLOW_BIT];
  assign fifo_pop  = !fifo_empty && tx_ready;
  // A full FIFO still takes a byte when a pop frees a slot on the same edge.
  assign fifo_push = txdata_wr && (!fifo_full || fifo_pop);

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clear)              overflow_d = 1'b0;
    if (txdata_wr && !fifo_push) overflow_d = 1'b1;
  end

  tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (write_memory_data[7:0]),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;

  always_comb begin
    status_word                                = '0;
    status_word[STATUS_FULL_BIT]               = fifo_full;
    status_word[STATUS_EMPTY_BIT]              = fifo_empty;
    status_word[STATUS_OVERFLOW_BIT]           = overflow_q;
    status_word[STATUS_COUNT_LSB +: 8]         = 8'(fifo_count);
  end

`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] cycle_hi_q, cycle_hi_d;

  always_comb begin
    cycle_d    = cycle_q + 64'd1;
    // Reading the low half freezes the high half so a LO-then-HI pair is coherent.
    cycle_hi_d = (rd_tgt == TGT_CYCLE_LO) ? cycle_q[63:32] : cycle_hi_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q    <= '0;
      cycle_hi_q <= '0;
    end else begin
      cycle_q    <= cycle_d;
      cycle_hi_q <= cycle_hi_d;
    end
  end

  assign cycle_lo = cycle_q[31:0];
  assign cycle_hi = cycle_hi_q;
`else
  assign cycle_lo = '0;
  assign cycle_hi = '0;
`endif

  always_comb begin
    case (rd_tgt)
      TGT_RAM:      read_data_d = mem[rd_idx];
      TGT_STATUS:   read_data_d = status_word;
      TGT_CYCLE_LO: read_data_d = cycle_lo;
      TGT_CYCLE_HI: read_data_d = cycle_hi;
      default:      read_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign read_memory_data = read_data_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_responder.sv
// ============================================================================
// tb_memory_responder: random + directed bench against a queue/array model.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_memory_responder;

  localparam int          MEMORY_WORDS = 1024;
  localparam int          DEPTH        = 8;
  localparam logic [31:0] MMIO         = 32'h8000_0000;
  localparam logic [31:0] A_TXDATA     = MMIO + 32'h0;
  localparam logic [31:0] A_STATUS     = MMIO + 32'h4;
  localparam logic [31:0] A_CYC_LO     = MMIO + 32'h8;
  localparam logic [31:0] A_CYC_HI     = MMIO + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] read_memory_address = '0;
  logic [31:0] read_memory_data;
  logic [31:0] write_memory_address = '0;
  logic [31:0] write_memory_data = '0;
  logic [31:0] write_memory_mask = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  always #5 clk = ~clk;

  memory_responder #(
    .MEMORY_WORDS  (MEMORY_WORDS),
    .MMIO_BASE     (MMIO),
    .TX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .read_memory_address  (read_memory_address),
    .read_memory_data     (read_memory_data),
    .write_memory_address (write_memory_address),
    .write_memory_data    (write_memory_data),
    .write_memory_mask    (write_memory_mask),
    .tx_data              (tx_data),
    .tx_valid             (tx_valid),
    .tx_ready             (tx_ready)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] ref_mem [MEMORY_WORDS];
  logic [7:0]  ref_q [$];
  logic        ref_ovf = 1'b0;
  logic [31:0] ref_hi = '0;
  logic [63:0] tb_cycles;

  // Elapsed clock edges since reset was last released.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cycles <= '0;
    else       tb_cycles <= tb_cycles + 64'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    logic [31:0] v;
    v = '0;
    if (addr[31] == 1'b0) begin
      v = ref_mem[addr[11:2]];
    end else begin
      case (addr[3:2])
        2'd1: v = {16'h0, 8'(ref_q.size()), 5'h0, ref_ovf,
                   (ref_q.size() == 0), (ref_q.size() == DEPTH)};
`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
        2'd2: v = tb_cycles[31:0];
        2'd3: v = ref_hi;
`endif
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  // Called at a negedge: applies one cycle of inputs, advances the model, checks after the edge.
  task automatic step(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [31:0] wm, input logic rdy);
    logic [31:0] exp_rd;
    logic        do_pop, push_req;
    read_memory_address  = ra;
    write_memory_address = wa;
    write_memory_data    = wd;
    write_memory_mask    = wm;
    tx_ready             = rdy;
    exp_rd   = ref_read(ra);
    do_pop   = (ref_q.size() != 0) && rdy;
    push_req = 1'b0;
    if (ra[31] && ra[3:2] == 2'd2) ref_hi = tb_cycles[63:32];
    if (wm != 0) begin
      if (!wa[31]) ref_mem[wa[11:2]] = (ref_mem[wa[11:2]] & ~wm) | (wd & wm);
      else if (wa[3:2] == 2'd0) push_req = (wm[7:0] != 0);
      else if (wa[3:2] == 2'd1 && wd[2] && wm[2]) ref_ovf = 1'b0;
    end
    if (do_pop) void'(ref_q.pop_front());
    if (push_req) begin
      if (ref_q.size() < DEPTH) ref_q.push_back(wd[7:0]);
      else                      ref_ovf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("read_data", read_memory_data, exp_rd);
    check_eq("tx_valid", {31'h0, tx_valid}, {31'h0, ref_q.size() != 0});
    if (ref_q.size() != 0) check_eq("tx_data", {24'h0, tx_data}, {24'h0, ref_q[0]});
  endtask

  task automatic idle(input logic rdy);
    step(32'h0, 32'h0, 32'h0, 32'h0, rdy);
  endtask

  function automatic logic [31:0] rand_ram_addr();
    return {1'b0, 19'($urandom), 4'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
  endfunction

  function automatic logic [31:0] rand_mmio_addr(input logic [1:0] off);
    return {1'b1, 27'($urandom), off, 2'($urandom)};
  endfunction

  function automatic logic [31:0] rand_mask();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'hFF << (8 * $urandom_range(0, 3));
      3:       return $urandom;
      4:       return 32'h4;
      default: return 32'hFFFF << (16 * $urandom_range(0, 1));
    endcase
  endfunction

  task automatic pulse_reset();
    #2 reset = 1'b1;
    write_memory_mask = '0;
    ref_q.delete();
    ref_ovf = 1'b0;
    ref_hi  = '0;
    #1;
    check_eq("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check_eq("reset_read_data", read_memory_data, 32'h0);
    check_eq("reset_tx_data", {24'h0, tx_data}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0]  last_byte;
    logic [31:0] ra, wa, wm;
    int          sel;

    #1 reset = 1'b1;
    #2;
    check_eq("reset_read_data", read_memory_data, 32'h0);
    check_eq("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check_eq("reset_tx_data", {24'h0, tx_data}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int w = 0; w < 64; w++) step(32'h0, 32'(w * 4), $urandom, 32'hFFFF_FFFF, 1'b0);

    // Partial-mask store merges with the previous word.
    step(32'h0, 32'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
    step(32'h0, 32'h10, 32'h0000_5500, 32'h0000_FF00, 1'b0);
    step(32'h10, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("partial_write", read_memory_data, 32'hDEAD_55EF);

    // Read-first collision.
    step(32'h0, 32'h20, 32'h7, 32'hFFFF_FFFF, 1'b0);
    step(32'h20, 32'h20, 32'h1, 32'hFFFF_FFFF, 1'b0);
    check_eq("read_first_old", read_memory_data, 32'h7);
    step(32'h20, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("read_first_new", read_memory_data, 32'h1);

    // Address wrap-around.
    step(32'h0, 32'h4, 32'hCAFE_0001, 32'hFFFF_FFFF, 1'b0);
    step(32'(MEMORY_WORDS * 4 + 4), 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("wrap_read", read_memory_data, 32'hCAFE_0001);

    // Overfill, drain, clear overflow.
    for (int i = 0; i < 9; i++) step(32'h0, A_TXDATA, 32'(8'h41 + i), 32'hFF, 1'b0);
    step(A_STATUS, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("status_full_ovf", read_memory_data, 32'h0000_0805);
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_order", {24'h0, tx_data}, 32'(8'h41 + i));
      idle(1'b1);
    end
    check_eq("drained_valid", {31'h0, tx_valid}, 32'h0);
    step(A_STATUS, 32'h0, 32'h0, 32'h0, 1'b1);
    check_eq("status_empty_ovf", read_memory_data, 32'h0000_0006);
    step(32'h0, A_STATUS, 32'h4, 32'h4, 1'b0);
    step(A_STATUS, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("status_cleared", read_memory_data, 32'h0000_0002);

    // Push into a full FIFO while it pops.
    for (int i = 0; i < 8; i++) step(32'h0, A_TXDATA, 32'(8'h61 + i), 32'hFF, 1'b0);
    step(32'h0, A_TXDATA, 32'h5A, 32'hFF, 1'b1);
    step(A_STATUS, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("status_full_no_ovf", read_memory_data, 32'h0000_0801);
    last_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last_byte = tx_data;
      idle(1'b1);
    end
    check_eq("last_drained", {24'h0, last_byte}, 32'h5A);

    // Cycle counter after a fresh reset.
    pulse_reset();
    for (int i = 0; i < 100; i++) idle(1'b0);
    step(A_CYC_LO, 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef MEMORY_RESPONDER_CYCLE_COUNTER_EN
    check_eq("cycle_lo_100", read_memory_data, 32'd100);
`else
    check_eq("cycle_lo_off", read_memory_data, 32'd0);
`endif
    step(A_CYC_HI, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("cycle_hi", read_memory_data, 32'h0);

    // Reset in the middle of a transfer.
    for (int i = 0; i < 3; i++) step(32'h0, A_TXDATA, 32'(8'h30 + i), 32'hFF, 1'b0);
    tx_ready = 1'b1;
    pulse_reset();
    step(A_CYC_LO, 32'h0, 32'h0, 32'h0, 1'b1);
    check_eq("cycle_lo_restart", read_memory_data, 32'h0);

    // Randomized traffic, alternating drain-heavy and fill-heavy phases.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 400; i++) begin
        ra  = ($urandom_range(0, 1) == 0) ? rand_ram_addr() : rand_mmio_addr(2'($urandom));
        sel = $urandom_range(0, 9);
        if (sel < 4)       wa = rand_ram_addr();
        else if (sel < 7)  wa = rand_mmio_addr(2'd0);
        else if (sel == 7) wa = rand_mmio_addr(2'd1);
        else               wa = rand_mmio_addr(2'($urandom_range(2, 3)));
        wm = (sel == 9) ? 32'h0 : rand_mask();
        step(ra, wa, $urandom, wm, ($urandom_range(0, 99) < ((p % 2 == 1) ? 80 : 20)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
